// File: rtl/cabletest_ctl_mc_if.sv
// ASHI register-bus bundle between the AXI4-Lite slave shim and the tester core.
// One-cycle write/read requests; responses are registered in the core.
interface cabletest_ctl_mc_if;
  logic [31:0] windx;
  logic [31:0] wdata;
  logic        write;
  logic [1:0]  wresp;
  logic        widle;
  logic [31:0] rindx;
  logic        read;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        ridle;

  modport master (output windx, wdata, write, rindx, read,
                  input  wresp, widle, rdata, rresp, ridle);
  modport slave  (input  windx, wdata, write, rindx, read,
                  output wresp, widle, rdata, rresp, ridle);
endinterface

// File: rtl/cabletest_ctl_mc.sv
// N-channel cable tester register/statistics core: config registers, start/halt/inject
// pulses, windowed per-channel counters with 64-bit snapshot reads, and a run timer.
module cabletest_ctl_mc_ch #(
  parameter int ERR_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        sent,
  input  logic        rcvd,
  input  logic        err,
  output logic [63:0] sent_cnt,
  output logic [63:0] rcvd_cnt,
  output logic [31:0] err_cnt
);
  logic [ERR_W-1:0] err_q;

  // clear wins over a strobe in the same cycle; error count sticks at all-ones
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sent_cnt <= '0;
      rcvd_cnt <= '0;
      err_q    <= '0;
    end else if (clr) begin
      sent_cnt <= '0;
      rcvd_cnt <= '0;
      err_q    <= '0;
    end else begin
      sent_cnt <= sent_cnt + 64'(sent);
      rcvd_cnt <= rcvd_cnt + 64'(rcvd);
      if (err && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = 32'(err_q);
endmodule

module cabletest_ctl_mc #(
  parameter int NUM_CH     = 2,
  parameter int ERR_W      = 32,
  parameter int DEF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               resetn,
  cabletest_ctl_mc_if.slave  ashi,
  input  logic [NUM_CH-1:0]  eth_up,
  output logic [NUM_CH-1:0]  pg_start,
  output logic [NUM_CH-1:0]  pg_halt,
  output logic [NUM_CH-1:0]  pg_inject,
  input  logic [NUM_CH-1:0]  pg_busy,
  input  logic [NUM_CH-1:0]  pg_halted,
  input  logic [NUM_CH-1:0]  pg_sent,
  input  logic [NUM_CH-1:0]  pr_rcvd,
  input  logic [NUM_CH-1:0]  pr_error,
  output logic [7:0]         cycles_per_packet,
  output logic [63:0]        packet_count
);
  localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;
  localparam logic [1:0] SNAP_NONE = 2'd0, SNAP_SENT = 2'd1, SNAP_RCVD = 2'd2, SNAP_ELAP = 2'd3;

  logic [NUM_CH-1:0] chan_en;
  logic [2:0]        chan_sel;
  logic [63:0]       elapsed;
  logic [31:0]       shadow;
  logic [1:0]        snap;
  logic              busy_any, clr;
  logic [7:0]        busy8, halted8, eth8, en8;
  logic [7:0][63:0]  sent_w, rcvd_w;
  logic [7:0][31:0]  err_w;
  logic [63:0]       sent_sel, rcvd_sel;
  logic [31:0]       err_sel;
  logic [1:0]        wr_resp, rd_resp;
  logic [31:0]       rd_data;

  assign busy_any = |(pg_busy & chan_en);
  assign clr      = |pg_start;

  // unused channel slots read as zero, so an out-of-range CHAN_SEL needs no special case
  for (genvar g = 0; g < 8; g++) begin : g_ch
    if (g < NUM_CH) begin : g_live
      cabletest_ctl_mc_ch #(.ERR_W(ERR_W)) u_ch (
        .clk(clk), .resetn(resetn), .clr(clr),
        .sent(pg_sent[g]), .rcvd(pr_rcvd[g]), .err(pr_error[g]),
        .sent_cnt(sent_w[g]), .rcvd_cnt(rcvd_w[g]), .err_cnt(err_w[g]));
    end else begin : g_pad
      assign sent_w[g] = '0;
      assign rcvd_w[g] = '0;
      assign err_w[g]  = '0;
    end
  end

  always_comb begin
    busy8   = '0; busy8[NUM_CH-1:0]   = pg_busy;
    halted8 = '0; halted8[NUM_CH-1:0] = pg_halted;
    eth8    = '0; eth8[NUM_CH-1:0]    = eth_up;
    en8     = '0; en8[NUM_CH-1:0]     = chan_en;
  end

  assign sent_sel = sent_w[chan_sel];
  assign rcvd_sel = rcvd_w[chan_sel];
  assign err_sel  = err_w[chan_sel];

  always_comb begin
    wr_resp = DECERR;
    case (ashi.windx)
      32'd2, 32'd3, 32'd4, 32'd6: wr_resp = busy_any ? SLVERR : OKAY;
      32'd5, 32'd8:               wr_resp = OKAY;
      default:                    wr_resp = DECERR;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    case (ashi.rindx)
      32'd0:  rd_data = 32'd2;
      32'd1:  rd_data = {8'b0, halted8, 8'b0, busy8};
      32'd2:  rd_data = {24'b0, cycles_per_packet};
      32'd3:  rd_data = packet_count[63:32];
      32'd4:  rd_data = packet_count[31:0];
      32'd6:  rd_data = {24'b0, en8};
      32'd7:  rd_data = {24'b0, eth8};
      32'd8:  rd_data = {29'b0, chan_sel};
      32'd9:  rd_data = sent_sel[63:32];
      32'd10: rd_data = (snap == SNAP_SENT) ? shadow : sent_sel[31:0];
      32'd11: rd_data = rcvd_sel[63:32];
      32'd12: rd_data = (snap == SNAP_RCVD) ? shadow : rcvd_sel[31:0];
      32'd13: rd_data = err_sel;
      32'd14: rd_data = elapsed[63:32];
      32'd15: rd_data = (snap == SNAP_ELAP) ? shadow : elapsed[31:0];
      default: rd_resp = DECERR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pg_start          <= '0;
      pg_halt           <= '0;
      pg_inject         <= '0;
      cycles_per_packet <= 8'(DEF_CYCLES);
      packet_count      <= '0;
      chan_en           <= '1;
      chan_sel          <= '0;
      ashi.wresp        <= OKAY;
    end else begin
      pg_start  <= '0;
      pg_halt   <= '0;
      pg_inject <= '0;
      if (ashi.write) ashi.wresp <= wr_resp;
      if (ashi.write && wr_resp == OKAY) begin
        case (ashi.windx)
          32'd2: cycles_per_packet <= ashi.wdata[7:0];
          32'd3: packet_count[63:32] <= ashi.wdata;
          32'd4: begin
            packet_count[31:0] <= ashi.wdata;
            if ({packet_count[63:32], ashi.wdata} != 64'd0) pg_start <= chan_en;
          end
          32'd5: begin
            pg_halt   <= chan_en & {NUM_CH{ashi.wdata[0]}};
            pg_inject <= chan_en & ashi.wdata[8 +: NUM_CH];
          end
          32'd6: chan_en  <= ashi.wdata[NUM_CH-1:0];
          32'd8: chan_sel <= ashi.wdata[2:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       elapsed <= '0;
    else if (clr)      elapsed <= '0;
    else if (busy_any) elapsed <= elapsed + 64'd1;
  end

  // H read latches the paired low word; the matching L read consumes it once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ashi.rdata <= '0;
      ashi.rresp <= OKAY;
      shadow     <= '0;
      snap       <= SNAP_NONE;
    end else if (ashi.read) begin
      ashi.rresp <= rd_resp;
      if (rd_resp != DECERR) ashi.rdata <= rd_data;
      case (ashi.rindx)
        32'd9:  begin shadow <= sent_sel[31:0]; snap <= SNAP_SENT; end
        32'd11: begin shadow <= rcvd_sel[31:0]; snap <= SNAP_RCVD; end
        32'd14: begin shadow <= elapsed[31:0];  snap <= SNAP_ELAP; end
        32'd10: if (snap == SNAP_SENT) snap <= SNAP_NONE;
        32'd12: if (snap == SNAP_RCVD) snap <= SNAP_NONE;
        32'd15: if (snap == SNAP_ELAP) snap <= SNAP_NONE;
        default: ;
      endcase
    end
  end

  assign ashi.widle = !ashi.write;
  assign ashi.ridle = !ashi.read;
endmodule
